// File: rtl/uart_rx_mode3.sv
// rtl/uart_rx_mode3.sv - 8051-style mode-3 (11-bit frame) serial receiver with SM2 filter
module uart_rx_mode3 #(
    parameter int CLK_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       ren,
    input  logic       sm2,
    input  logic       ri_clr,
    output logic [7:0] rx_data,
    output logic       rb8,
    output logic       ri,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        BIT9  = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam logic [13:0] LAST = 14'(CLK_PER_BIT - 1);
    localparam logic [13:0] HALF = 14'(CLK_PER_BIT / 2);

    state_t      state_q, state_d;
    logic [13:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        bit9_q, bit9_d;
    logic [1:0]  samp_q, samp_d;
    logic        rx_meta_q, rx_s_q, rx_prev_q;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rb8_q, rb8_d;
    logic        ri_q, ri_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    logic maj;
    logic at_h_m1, at_h, at_h_p1, at_end;

    assign rx_data   = rx_data_q;
    assign rb8       = rb8_q;
    assign ri        = ri_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    // Sample-point decode; the majority vote uses the two stored samples plus the live one
    always_comb begin
        at_h_m1 = (clk_cnt_q == HALF - 14'd1);
        at_h    = (clk_cnt_q == HALF);
        at_h_p1 = (clk_cnt_q == HALF + 14'd1);
        at_end  = (clk_cnt_q == LAST);
        maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    end

    // Next-state, bit assembly and the stop-bit load/filter decision
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = at_end ? 14'd0 : clk_cnt_q + 14'd1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        bit9_d      = bit9_q;
        samp_d      = samp_q;
        rx_data_d   = rx_data_q;
        rb8_d       = rb8_q;
        ri_d        = ri_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;

        if (ri_clr) begin
            ri_d      = 1'b0;
            overrun_d = 1'b0;
        end

        if (at_h_m1) samp_d[0] = rx_s_q;
        if (at_h)    samp_d[1] = rx_s_q;

        case (state_q)
            IDLE: begin
                clk_cnt_d = 14'd0;
                bit_idx_d = 3'd0;
                if (ren && rx_prev_q && !rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (at_h_p1 && maj) begin
                    state_d   = IDLE;
                    clk_cnt_d = 14'd0;
                end else if (at_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_h_p1) shift_d = {maj, shift_q[7:1]};
                if (at_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = BIT9;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            BIT9: begin
                if (at_h_p1) bit9_d = maj;
                if (at_end) state_d = STOP;
            end
            STOP: begin
                // Decide at the stop-bit sample point so a back-to-back start edge is not missed
                if (at_h_p1) begin
                    state_d   = IDLE;
                    clk_cnt_d = 14'd0;
                    if (!maj) begin
                        frame_err_d = 1'b1;
                    end else if (ri_q) begin
                        overrun_d = 1'b1;
                    end else if (sm2 && !bit9_q) begin
                        ri_d = ri_d;
                    end else begin
                        rx_data_d = shift_q;
                        rb8_d     = bit9_q;
                        ri_d      = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = 14'd0;
            end
        endcase
    end

    // Input synchronizer, edge history and all registered state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= IDLE;
            clk_cnt_q   <= 14'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            bit9_q      <= 1'b0;
            samp_q      <= 2'b11;
            rx_data_q   <= 8'd0;
            rb8_q       <= 1'b0;
            ri_q        <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            bit9_q      <= bit9_d;
            samp_q      <= samp_d;
            rx_data_q   <= rx_data_d;
            rb8_q       <= rb8_d;
            ri_q        <= ri_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_mode3.sv
// tb/tb_uart_rx_mode3.sv - randomized self-checking bench for uart_rx_mode3
module tb_uart_rx_mode3;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ren = 1'b0;
    logic       sm2 = 1'b0;
    logic       ri_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rb8;
    logic       ri;
    logic       frame_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_data;
    logic       m_rb8, m_ri, m_ovr;
    int         m_fe;

    int  fe_cnt = 0;
    int  fe_wide = 0;
    logic fe_prev = 1'b0;

    uart_rx_mode3 #(.CLK_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .ren(ren), .sm2(sm2), .ri_clr(ri_clr),
        .rx_data(rx_data), .rb8(rb8), .ri(ri), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (frame_err && fe_prev) fe_wide <= fe_wide + 1;
        fe_prev <= frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data = 8'd0; m_rb8 = 1'b0; m_ri = 1'b0; m_ovr = 1'b0;
    endtask

    // Receiver rules applied to one complete frame
    task automatic model_frame(input logic [7:0] d, input logic b9, input logic stopb, input logic s);
        if (!stopb)           m_fe++;
        else if (m_ri)        m_ovr = 1'b1;
        else if (s && !b9)    ;
        else begin
            m_data = d; m_rb8 = b9; m_ri = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic b9, input logic stopb, input int idle);
        logic [10:0] bits;
        bits = {stopb, b9, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        if (ren) model_frame(d, b9, stopb, sm2);
        repeat (idle) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk); ri_clr = 1'b1;
        @(negedge clk); ri_clr = 1'b0;
        m_ri = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ri"}, 32'(ri), 32'(m_ri));
        chk({tag, ".data"}, 32'(rx_data), 32'(m_data));
        chk({tag, ".rb8"}, 32'(rb8), 32'(m_rb8));
        chk({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
        chk({tag, ".fe"}, 32'(fe_cnt), 32'(m_fe));
    endtask

    initial begin
        logic [7:0] d;
        logic       b9, sb, last_bad;
        int         idle;

        model_reset();
        m_fe = 0;
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset.fe_lvl", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        ren = 1'b1;
        repeat (5) @(negedge clk);

        // 1: plain byte
        send_frame(8'hA5, 1'b0, 1'b1, 4);
        check_all("t1");
        chk("t1.lit", 32'(rx_data), 32'hA5);
        pulse_clr();

        // 2: multiprocessor filter
        sm2 = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, 4);
        check_all("t2a");
        send_frame(8'h7E, 1'b1, 1'b1, 4);
        check_all("t2b");
        chk("t2b.lit", 32'({rb8, rx_data}), 32'h17E);
        pulse_clr();
        sm2 = 1'b0;

        // 3: glitch is a false start
        rx = 1'b0; repeat (4) @(negedge clk);
        rx = 1'b1; repeat (30) @(negedge clk);
        check_all("t3glitch");
        send_frame(8'h55, 1'b0, 1'b1, 4);
        check_all("t3");
        pulse_clr();

        // 4: overrun
        send_frame(8'h12, 1'b0, 1'b1, 0);
        send_frame(8'h34, 1'b1, 1'b1, 4);
        check_all("t4");
        chk("t4.lit", 32'({overrun, rx_data}), 32'h112);
        pulse_clr();
        check_all("t4clr");

        // 5: framing error
        send_frame(8'h99, 1'b0, 1'b0, 8);
        check_all("t5");

        // ren low: line ignored
        ren = 1'b0;
        send_frame(8'hC3, 1'b1, 1'b1, 8);
        check_all("ren0");
        ren = 1'b1;

        // 6: reset in the middle of D4
        rx = 1'b0; repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0]; repeat (CPB) @(negedge clk);
        end
        rx = 1'b1; repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        check_all("t6rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        check_all("t6a");
        pulse_clr();
        send_frame(8'h0F, 1'b1, 1'b1, 0);
        check_all("t6b");

        // Random frames
        last_bad = 1'b0;
        for (int n = 0; n < 40; n++) begin
            d  = 8'($urandom);
            b9 = 1'($urandom);
            sb = ($urandom_range(0, 9) != 0);
            sm2 = 1'($urandom);
            if ($urandom_range(0, 1) == 1) pulse_clr();
            if (last_bad) repeat (4) @(negedge clk);
            idle = sb ? $urandom_range(0, 5) : $urandom_range(4, 8);
            send_frame(d, b9, sb, idle);
            check_all($sformatf("rnd%0d", n));
            last_bad = !sb;
        end

        repeat (4) @(negedge clk);
        chk("fe_width", 32'(fe_wide), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
